// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the cache-to-memory line bridge.
// Optional build macro used by mem_bridge: MEM_BRIDGE_CRIT_FIRST_EN.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_t;

    localparam int BEAT_BYTES = 8;

    localparam logic [7:0] TRSC_GETI = 8'd0;
    localparam logic [7:0] TRSC_GETV = 8'd1;

    // Any transaction code other than GetI is serviced as a read.
    function automatic logic is_getv(input logic [7:0] trsc);
        return (trsc == TRSC_GETV) || (trsc != TRSC_GETI);
    endfunction

endpackage

// File: rtl/beat_sched.sv
// Beat sequencer: picks the next beat to issue (strobe skipping, rotated start)
// and remembers the indices of granted-but-unacknowledged beats in order.
module beat_sched
    import mem_bridge_pkg::*;
#(
    parameter int blk    = 64,
    parameter int maxout = 4,
    localparam int NB = blk / BEAT_BYTES,
    localparam int IW = (NB > 1) ? $clog2(NB) : 1,
    localparam int OW = $clog2(maxout) + 1,
    localparam int PW = (maxout > 1) ? $clog2(maxout) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [blk-1:0] strb,
    input  logic           getv,
    input  logic [IW-1:0]  start,
    input  logic           issue,
    input  logic           ack,
    output logic [IW-1:0]  nxt,
    output logic           more,
    output logic           full,
    output logic [IW-1:0]  head,
    output logic           last
);

    logic [NB-1:0] mask;
    logic [NB-1:0] done_q;
    logic [NB-1:0] pend;
    logic          found;
    logic          pop;

    logic [IW-1:0] fifo_q [maxout];
    logic [PW-1:0] wp_q;
    logic [PW-1:0] rp_q;
    logic [OW-1:0] cnt_q;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(maxout - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mask = '0;
        for (int j = 0; j < NB; j++) begin
            mask[j] = getv || (strb[j*BEAT_BYTES +: BEAT_BYTES] != '0);
        end
    end

    assign pend = mask & ~done_q;
    assign more = |pend;

    // First pending beat in rotated order starting at 'start'.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = 0; i < NB; i++) begin
            int k;
            k = (int'(start) + i) % NB;
            if (!found && pend[k]) begin
                nxt   = IW'(k);
                found = 1'b1;
            end
        end
    end

    assign pop  = ack && (cnt_q != '0);
    assign head = fifo_q[rp_q];
    assign full = (cnt_q == OW'(maxout));
    assign last = (cnt_q == OW'(1)) && !more;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= '0;
        end else if (load) begin
            done_q <= '0;
        end else if (issue) begin
            done_q[nxt] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < maxout; i++) fifo_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (issue) begin
                fifo_q[wp_q] <= nxt;
                wp_q         <= bump(wp_q);
            end
            if (pop) rp_q <= bump(rp_q);
            if (issue && !pop) cnt_q <= cnt_q + 1'b1;
            else if (!issue && pop) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// Whole-line request to 64-bit pipelined memory bus bridge (fills and evictions).
// Build macro MEM_BRIDGE_CRIT_FIRST_EN: reads start at the addressed beat and wrap.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int blk    = 64,
    parameter int maxout = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_rqst,
    input  logic [7:0]       s_trsc,
    input  logic [blk-1:0]   s_strb,
    input  logic [63:0]      s_addr,
    input  logic [blk*8-1:0] s_wdat,
    output logic [7:0]       s_resp,
    output logic [7:0]       s_miss,
    output logic [63:0]      s_ofst,
    output logic [blk*8-1:0] s_rdat,
    output logic             mem_req,
    output logic             mem_we,
    output logic [63:0]      mem_addr,
    output logic [7:0]       mem_wstrb,
    output logic [63:0]      mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [63:0]      mem_rdata
);

    localparam int NB = blk / BEAT_BYTES;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int BW = BEAT_BYTES * 8;

    state_t           state;
    logic [7:0]       id_q;
    logic             getv_q;
    logic [blk-1:0]   strb_q;
    logic [63:0]      addr_q;
    logic [63:0]      base_q;
    logic [blk*8-1:0] wdat_q;
    logic [blk*8-1:0] line_q;
    logic [IW-1:0]    start_q;

    logic [IW-1:0] nxt;
    logic [IW-1:0] head;
    logic          more;
    logic          full;
    logic          last;
    logic          load;
    logic          issue;
    logic          ack;

    assign load  = (state == IDLE) && (s_rqst != 8'd0);
    assign ack   = (state == XFER) && mem_rvalid;

    // mem_req only drops on a grant or when the last beat is issued, so the
    // beat fields stay stable while a request waits for mem_gnt.
    assign mem_req   = (state == XFER) && more && !full;
    assign issue     = mem_req && mem_gnt;
    assign mem_we    = mem_req && !getv_q;
    assign mem_addr  = mem_req ? base_q + 64'({nxt, 3'b000}) : '0;
    assign mem_wstrb = mem_req ? strb_q[int'(nxt)*BEAT_BYTES +: BEAT_BYTES] : '0;
    assign mem_wdata = mem_req ? wdat_q[int'(nxt)*BW +: BW] : '0;

    assign s_resp = (state == RESP) ? id_q : '0;
    assign s_miss = '0;
    assign s_ofst = (state == RESP) ? addr_q : '0;
    assign s_rdat = ((state == RESP) && getv_q) ? line_q : '0;

    beat_sched #(
        .blk    (blk),
        .maxout (maxout)
    ) u_sched (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .strb  (strb_q),
        .getv  (getv_q),
        .start (start_q),
        .issue (issue),
        .ack   (ack),
        .nxt   (nxt),
        .more  (more),
        .full  (full),
        .head  (head),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            id_q    <= '0;
            getv_q  <= 1'b0;
            strb_q  <= '0;
            addr_q  <= '0;
            base_q  <= '0;
            wdat_q  <= '0;
            line_q  <= '0;
            start_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        id_q   <= s_rqst;
                        getv_q <= is_getv(s_trsc);
                        strb_q <= s_strb;
                        addr_q <= s_addr;
                        base_q <= s_addr & ~64'(blk - 1);
                        wdat_q <= s_wdat;
`ifdef MEM_BRIDGE_CRIT_FIRST_EN
                        start_q <= is_getv(s_trsc) ? IW'(s_addr >> 3) : '0;
`else
                        start_q <= '0;
`endif
                        // A clean eviction has nothing to move.
                        state <= ((s_trsc == TRSC_GETI) && (s_strb == '0)) ? RESP : XFER;
                    end
                end
                XFER: begin
                    if (ack && getv_q) line_q[int'(head)*BW +: BW] <= mem_rdata;
                    if (ack && last) state <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: vector table of line transactions plus
// hand-written reset/flush sequences, with a beat scoreboard in the memory model.
module tb_mem_bridge;

    localparam int BLK    = 64;
    localparam int MAXOUT = 2;
    localparam int NB     = BLK / 8;
    localparam logic [511:0] WPAT = {64'h7777_8888_9999_AAAA, 64'h6666_5555_4444_3333,
                                     64'hDEAD_BEEF_0000_0007, 64'h0123_4567_89AB_CDEF,
                                     64'hFEDC_BA98_7654_3210, 64'h1111_2222_3333_4444,
                                     64'hC0DE_0000_1234_5678, 64'h0BAD_F00D_CAFE_0001};

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       s_rqst, s_trsc;
    logic [BLK-1:0]   s_strb;
    logic [63:0]      s_addr;
    logic [BLK*8-1:0] s_wdat;
    logic [7:0]       s_resp, s_miss;
    logic [63:0]      s_ofst;
    logic [BLK*8-1:0] s_rdat;
    logic             mem_req, mem_we;
    logic [63:0]      mem_addr, mem_wdata;
    logic [7:0]       mem_wstrb;
    logic             mem_gnt    = 1'b0;
    logic             mem_rvalid = 1'b0;
    logic [63:0]      mem_rdata  = '0;

    mem_bridge #(.blk(BLK), .maxout(MAXOUT)) dut (
        .clk(clk), .rst(rst),
        .s_rqst(s_rqst), .s_trsc(s_trsc), .s_strb(s_strb), .s_addr(s_addr), .s_wdat(s_wdat),
        .s_resp(s_resp), .s_miss(s_miss), .s_ofst(s_ofst), .s_rdat(s_rdat),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
    } beat_t;

    typedef struct {
        int          due;
        logic [63:0] data;
    } rv_t;

    typedef struct {
        logic [7:0]   id;
        logic [7:0]   trsc;
        logic [63:0]  strb;
        logic [63:0]  addr;
        logic [511:0] wdat;
        logic [63:0]  seed;
        int           gmode;
        int           dly;
        int           lat;
        int           wd;
    } vec_t;

    beat_t       exp_q[$];
    rv_t         pq[$];
    int          tests = 0;
    int          fails = 0;
    int          gnt_mode = 0;
    int          rdly = 1;
    int          outst = 0;
    int          gcount = 0;
    int          stale_cnt = 0;
    logic [63:0] rd_seed = '0;
    logic        held_v = 1'b0;
    beat_t       held;

    function automatic logic [63:0] rd_pat(input logic [63:0] seed, input int k);
        return {seed[55:0], 8'(k)};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Memory model: grants, in-order acknowledges and the beat scoreboard.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        logic  g;
        if (rst) begin
            pq.delete();
            outst      = 0;
            held_v     = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end else begin
            cur.addr  = mem_addr;
            cur.we    = mem_we;
            cur.wstrb = mem_wstrb;
            cur.wdata = mem_wdata;
            if (held_v) begin
                chk("req_held", {511'd0, mem_req}, 512'd1);
                chk("hold_addr", cur.addr, held.addr);
                chk("hold_data", {cur.we, cur.wstrb, cur.wdata}, {held.we, held.wstrb, held.wdata});
            end
            if (mem_req) chk("outstanding_limit", {511'd0, outst < MAXOUT}, 512'd1);
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (stale_cnt > 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 64'hBADB_ADBA_DBAD_BADB;
                stale_cnt--;
            end else if (pq.size() > 0 && pq[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pq[0].data;
                void'(pq.pop_front());
                outst--;
            end
            g = (gnt_mode == 0) ? 1'b1 : cyc[0];
            mem_gnt = g;
            if (mem_req && g) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got addr %0h required no beat", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_addr", cur.addr, e.addr);
                    chk("beat_we", {511'd0, cur.we}, {511'd0, e.we});
                    chk("beat_wstrb", {504'd0, cur.wstrb}, {504'd0, e.wstrb});
                    chk("beat_wdata", cur.wdata, e.wdata);
                end
                pq.push_back('{due: cyc + rdly, data: rd_pat(rd_seed, int'(mem_addr[5:3]))});
                outst++;
                gcount++;
            end
            held_v = mem_req && !g;
            held   = cur;
        end
    end

    task automatic run_txn(input vec_t v);
        logic [511:0] erd;
        beat_t        b;
        int           start, t0, k;
        bit           got;
        logic         getv;
        getv  = (v.trsc != 8'd0);
        erd   = '0;
        start = 0;
`ifdef MEM_BRIDGE_CRIT_FIRST_EN
        if (getv) start = int'(v.addr[5:3]);
`endif
        for (int i = 0; i < NB; i++) begin
            k = getv ? (start + i) % NB : i;
            if (getv || v.strb[k*8 +: 8] != 8'd0) begin
                b.addr  = {v.addr[63:6], 6'b0} + 64'(k * 8);
                b.we    = !getv;
                b.wstrb = v.strb[k*8 +: 8];
                b.wdata = v.wdat[k*64 +: 64];
                exp_q.push_back(b);
            end
            if (getv) erd[k*64 +: 64] = rd_pat(v.seed, k);
        end
        gnt_mode = v.gmode;
        rdly     = v.dly;
        rd_seed  = v.seed;
        s_rqst = v.id; s_trsc = v.trsc; s_strb = v.strb; s_addr = v.addr; s_wdat = v.wdat;
        t0  = cyc;
        got = 1'b0;
        for (int n = 1; n <= 300 && !got; n++) begin
            step();
            if (s_resp != 8'd0) got = 1'b1;
            else if (n == v.wd) begin
                s_rqst = 8'd0;
                s_addr = ~v.addr;
                s_strb = ~v.strb;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout id %0h: got no s_resp required %0h", v.id, v.id);
        end else begin
            chk("resp_id", {504'd0, s_resp}, {504'd0, v.id});
            chk("resp_ofst", {448'd0, s_ofst}, {448'd0, v.addr});
            chk("resp_rdat", s_rdat, erd);
            chk("resp_miss", {504'd0, s_miss}, 512'd0);
            if (v.lat > 0) chk("latency", 512'(cyc - t0), 512'(v.lat));
            chk("beats_left", 512'(exp_q.size()), 512'd0);
        end
        s_rqst = '0; s_trsc = '0; s_strb = '0; s_addr = '0; s_wdat = '0;
        step();
        chk("resp_pulse", {504'd0, s_resp}, 512'd0);
        exp_q.delete();
    endtask

    vec_t vt [8];

    initial begin
        beat_t b;
        int    g0;
        rst = 1'b1;
        s_rqst = '0; s_trsc = '0; s_strb = '0; s_addr = '0; s_wdat = '0;
        repeat (2) step();
        chk("rst_resp", {504'd0, s_resp}, 512'd0);
        chk("rst_miss", {504'd0, s_miss}, 512'd0);
        chk("rst_ofst", {448'd0, s_ofst}, 512'd0);
        chk("rst_rdat", s_rdat, 512'd0);
        chk("rst_req", {511'd0, mem_req}, 512'd0);
        chk("rst_beat", {mem_we, mem_addr, mem_wstrb, mem_wdata}, 512'd0);
        rst = 1'b0;
        step();

        //        id     trsc   strb                   addr                   wdat   seed                   gm dly lat wd
        vt[0] = '{8'h40, 8'h00, 64'h0,                 64'h0000_0000_2000_0010, '0,    64'h0,                 0, 1, 1,  0};
        vt[1] = '{8'h11, 8'h01, 64'h0,                 64'h0000_0000_1000_0048, '0,    64'h0,                 0, 1, 10, 0};
        vt[2] = '{8'h33, 8'h00, 64'hFF00_0000_0000_FF00, 64'h0000_0004_0000_0100, WPAT, 64'h0,                 0, 1, 4,  0};
        vt[3] = '{8'h5A, 8'h01, 64'h0,                 64'h0000_0000_3000_00C0, '0,    64'h00AB_CDEF_0000_0001, 1, 5, 0,  0};
        vt[4] = '{8'h6B, 8'h00, 64'h00FF_0000_0301_0080, 64'h0000_0000_3000_0100, WPAT, 64'h0,                 1, 5, 0,  0};
        vt[5] = '{8'h7E, 8'h07, 64'h0,                 64'h0000_0000_ABCD_0028, '0,    64'h0000_0000_0000_0005, 0, 2, 0,  0};
        vt[6] = '{8'hC3, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0040, ~WPAT, 64'h0,                0, 1, 10, 0};
        vt[7] = '{8'h44, 8'h01, 64'h0,                 64'h0000_0000_5000_0008, '0,    64'h0000_0000_0000_0009, 0, 1, 10, 3};
        for (int i = 0; i < 8; i++) run_txn(vt[i]);

        // Reset in the middle of a read after three grants.
        gnt_mode = 0; rdly = 1; rd_seed = '0;
        for (int k = 0; k < NB; k++) begin
            b.addr = 64'h6000_0000 + 64'(k * 8); b.we = 1'b0; b.wstrb = '0; b.wdata = '0;
            exp_q.push_back(b);
        end
        s_rqst = 8'h99; s_trsc = 8'h01; s_addr = 64'h6000_0000;
        g0 = gcount;
        for (int n = 0; n < 50 && (gcount - g0) < 3; n++) step();
        chk("grants_before_reset", 512'(gcount - g0), 512'd3);
        rst = 1'b1;
        #1;
        chk("midrst_req", {511'd0, mem_req}, 512'd0);
        chk("midrst_addr", {448'd0, mem_addr}, 512'd0);
        chk("midrst_resp", {504'd0, s_resp}, 512'd0);
        s_rqst = '0; s_trsc = '0; s_addr = '0;
        exp_q.delete();
        repeat (2) step();
        rst = 1'b0;
        stale_cnt = 3;
        repeat (4) step();
        chk("stale_req", {511'd0, mem_req}, 512'd0);
        chk("stale_resp", {504'd0, s_resp}, 512'd0);
        run_txn('{8'h22, 8'h01, 64'h0, 64'h0000_0000_7000_0018, '0, 64'h0000_0000_0000_0022, 1, 3, 0, 0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Downstream neighbour of the cache master port.
- Accepts one whole-line request at a time (request-ID protocol: request held until a matching response ID) and serialises it into 64-bit beats on a pipelined memory bus.
- Reassembles read data into a line, then returns a one-cycle response carrying the request ID.
- Serves both line fills (GetV) and dirty evictions (GetI with write strobes).

Parameters:
- blk, 64, line size in bytes; multiple of 8, at least 8.
- maxout, 4, maximum granted-but-unacknowledged beats on the memory bus.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- s_rqst  in  8  request ID; 0 = idle.
- s_trsc  in  8  transaction: 0 = GetI (evict/write), 1 = GetV (read); others treated as GetV.
- s_strb  in  blk  byte write strobe.
- s_addr  in  64  physical address.
- s_wdat  in  blk*8  write line.
- s_resp  out  8  response ID, one-cycle pulse.
- s_miss  out  8  miss ID; always 0.
- s_ofst  out  64  captured address of the responded request.
- s_rdat  out  blk*8  read line.
- mem_req  out  1  beat request valid.
- mem_we  out  1  beat is a write.
- mem_addr  out  64  beat address, 8-byte aligned.
- mem_wstrb  out  8  beat byte strobe.
- mem_wdata  out  64  beat write data.
- mem_gnt  in  1  beat accepted this cycle when mem_req=1.
- mem_rvalid  in  1  one in-order acknowledge per granted beat; carries data for reads.
- mem_rdata  in  64  read beat data.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, counters 0, line buffer 0. Reset mid-transaction aborts it with no response. mem_rvalid arriving in IDLE is ignored.
- States: IDLE, XFER, RESP.
- IDLE: if s_rqst!=0, capture rqst/trsc/strb/addr/wdat; line base = addr with low log2(blk) bits cleared.
  - If GetI with s_strb==0 (clean evict): go to RESP.
  - Otherwise: go to XFER.
- Beat set:
  - GetV: all blk/8 beats.
  - GetI: only beats whose 8-bit strobe slice is nonzero.
- Beat order: ascending beat index (see optional feature).
- XFER, issue side:
  - mem_req=1 while beats remain unissued and outstanding<maxout.
  - Drive mem_addr = base + 8*k, mem_we = (GetI), mem_wstrb/mem_wdata = slice k.
  - Signals hold stable until mem_gnt; advance to the next beat on mem_gnt.
- XFER, return side: on mem_rvalid for a read, write mem_rdata into line slice of the oldest outstanding beat. Outstanding count: +1 on gnt, -1 on rvalid; both in the same cycle leaves it unchanged.
- XFER exits to RESP the cycle after the final mem_rvalid.
- RESP (one cycle):
  - s_resp = captured ID, s_miss = 0, s_ofst = captured addr.
  - s_rdat = assembled line for GetV, 0 for GetI.
  - Next state IDLE. s_resp is 0 in every other state.
- Requests seen while busy are ignored. Upstream holds them until responded.
- A request withdrawn or changed mid-transaction (upstream flush) does not abort. The captured transaction completes and responds with its captured ID; upstream discards a non-matching ID.
- Latency:
  - Clean evict: request in IDLE at cycle t gives s_resp at t+1.
  - Read with mem_gnt=1 always and rvalid one cycle after gnt, blk=64, maxout>=8: beats granted t+1..t+8, s_resp at t+10.
- Internal counters are log2(blk/8)+1 bits wide. The outstanding counter is log2(maxout)+1 bits and never exceeds maxout.

Optional Feature:
- Macro: MEM_BRIDGE_CRIT_FIRST_EN.
- When defined, GetV beats start at beat index s_addr[log2(blk)-1:3] and wrap modulo blk/8. Data is still placed by beat index, so s_rdat is identical; only mem_addr order changes. GetI order is unchanged.
- When undefined, all transactions issue in ascending order from beat 0.

Decomposition:
- Package mem_bridge_pkg holds:
  - the state enum (IDLE/XFER/RESP);
  - BEAT_BYTES=8;
  - TRSC_GETI=8'd0 and TRSC_GETV=8'd1.
- Sub-module beat_sched owns beat sequencing:
  - inputs: captured strobe, transaction type, start index;
  - outputs: next beat index and last-beat flag;
  - handles strobe skipping, the critical-first wrap, and a FIFO of beat indices for outstanding beats.

Test Plan:
- Clean evict: s_rqst=8'h40, s_trsc=0, s_strb=0 -> s_resp=8'h40 one cycle later; mem_req never asserted.
- Full read: s_rqst=8'h11, s_trsc=1, s_addr=64'h1000_0048, mem_gnt=1, rdata=beat index -> mem_addr 64'h1000_0040..78 in order; s_resp=8'h11 at t+10; s_rdat slice k=k; s_ofst=64'h1000_0048.
- Partial write: s_trsc=0, s_strb only bytes 8-15 and 56-63 set -> exactly 2 beats (addr +8, +56) with mem_wstrb=8'hff; s_resp after the 2nd rvalid; s_rdat=0.
- Backpressure: maxout=2, mem_gnt toggling, rvalid delayed 5 cycles -> outstanding never exceeds 2; mem_req signals stable while ungranted; line correct.
- Reset mid-XFER after 3 grants -> outputs 0 immediately; a following request 8'h22 is served normally; stale rvalids in IDLE are ignored.
- With MEM_BRIDGE_CRIT_FIRST_EN, read at s_addr offset 0x28 -> beat order 5,6,7,0,1,2,3,4; s_rdat identical to the ascending-order case.
